// File: rtl/lsu_pkg.sv
// Shared types, widths and helpers for the load/store unit.
package lsu_pkg;

  localparam int unsigned CPU_WIDTH = 64;
  localparam int unsigned REG_ADDRW = 5;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } lsu_state_e;

  // Access size encodings
  localparam logic [1:0] LS_B = 2'b00;
  localparam logic [1:0] LS_H = 2'b01;
  localparam logic [1:0] LS_W = 2'b10;
  localparam logic [1:0] LS_D = 2'b11;

  // Byte-enable patterns for an access at offset 0
  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    unique case (size)
      LS_B:    m = MASK_B;
      LS_H:    m = MASK_H;
      LS_W:    m = MASK_W;
      default: m = MASK_D;
    endcase
    return m;
  endfunction

  // Natural alignment check on the low address bits
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    logic mis;
    unique case (size)
      LS_B:    mis = 1'b0;
      LS_H:    mis = off[0];
      LS_W:    mis = |off[1:0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Pipeline and data-memory signals of the load/store unit, seen from the LSU (slave)
// and from its environment (master).
interface lsu_if;
  import lsu_pkg::*;

  // EX/LS side
  logic                 i_exu_valid;
  logic                 o_lsu_ready;
  logic [CPU_WIDTH-1:0] i_exu_exres;
  logic [CPU_WIDTH-1:0] i_exu_rs2;
  logic [REG_ADDRW-1:0] i_exu_rdid;
  logic                 i_exu_rdwen;
  logic                 i_exu_ldflag;
  logic                 i_exu_stflag;
  logic [1:0]           i_exu_lssize;
  logic                 i_exu_lsuns;

  // LS/WB side
  logic                 o_lsu_valid;
  logic                 i_wbu_ready;
  logic [CPU_WIDTH-1:0] o_lsu_exres;
  logic [CPU_WIDTH-1:0] o_lsu_lsres;
  logic [REG_ADDRW-1:0] o_lsu_rdid;
  logic                 o_lsu_rdwen;
  logic                 o_lsu_ldflag;
  logic                 o_lsu_misalign;

  // Data memory
  logic                 o_dmem_req;
  logic                 i_dmem_gnt;
  logic                 o_dmem_wen;
  logic [CPU_WIDTH-1:0] o_dmem_addr;
  logic [63:0]          o_dmem_wdata;
  logic [7:0]           o_dmem_wmask;
  logic                 i_dmem_rvalid;
  logic [63:0]          i_dmem_rdata;

  modport slave (
    input  i_exu_valid, i_exu_exres, i_exu_rs2, i_exu_rdid, i_exu_rdwen, i_exu_ldflag,
           i_exu_stflag, i_exu_lssize, i_exu_lsuns, i_wbu_ready, i_dmem_gnt,
           i_dmem_rvalid, i_dmem_rdata,
    output o_lsu_ready, o_lsu_valid, o_lsu_exres, o_lsu_lsres, o_lsu_rdid, o_lsu_rdwen,
           o_lsu_ldflag, o_lsu_misalign, o_dmem_req, o_dmem_wen, o_dmem_addr,
           o_dmem_wdata, o_dmem_wmask
  );

  modport master (
    output i_exu_valid, i_exu_exres, i_exu_rs2, i_exu_rdid, i_exu_rdwen, i_exu_ldflag,
           i_exu_stflag, i_exu_lssize, i_exu_lsuns, i_wbu_ready, i_dmem_gnt,
           i_dmem_rvalid, i_dmem_rdata,
    input  o_lsu_ready, o_lsu_valid, o_lsu_exres, o_lsu_lsres, o_lsu_rdid, o_lsu_rdwen,
           o_lsu_ldflag, o_lsu_misalign, o_dmem_req, o_dmem_wen, o_dmem_addr,
           o_dmem_wdata, o_dmem_wmask
  );

endinterface

// File: rtl/lsu_ldext.sv
// Load data alignment: shift the 64-bit beat down by the byte offset, truncate to the
// access size and sign- or zero-extend.
module lsu_ldext
  import lsu_pkg::*;
(
  input  logic [63:0] rdata_i,
  input  logic [2:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [63:0] data_o
);

  logic [63:0] shifted;

  assign shifted = rdata_i >> {off_i, 3'b000};

  // Truncate and extend according to access size
  always_comb begin
    data_o = shifted;
    unique case (size_i)
      LS_B:    data_o = {{56{~uns_i & shifted[7]}},  shifted[7:0]};
      LS_H:    data_o = {{48{~uns_i & shifted[15]}}, shifted[15:0]};
      LS_W:    data_o = {{32{~uns_i & shifted[31]}}, shifted[31:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one instruction from EX/LS, runs the data-memory
// request/grant/response exchange and presents the result toward LS/WB.
module lsu
  import lsu_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst_n,
  lsu_if.slave  bus
);

  lsu_state_e state_q, state_d;

  logic [CPU_WIDTH-1:0] exres_q, exres_d, lsres_q, lsres_d, addr_q, addr_d;
  logic [REG_ADDRW-1:0] rdid_q, rdid_d;
  logic                 rdwen_q, rdwen_d, ldflag_q, ldflag_d, stflag_q, stflag_d;
  logic                 misalign_q, misalign_d, uns_q, uns_d;
  logic [1:0]           size_q, size_d;
  logic                 wen_q, wen_d, req_q, req_d, valid_q, valid_d;
  logic [63:0]          wdata_q, wdata_d;
  logic [7:0]           wmask_q, wmask_d;

  logic        ready, accept;
  logic        new_mem, new_mis, new_go, new_st;
  logic [63:0] ld_data;

  assign ready  = (state_q == StIdle) || ((state_q == StDone) && bus.i_wbu_ready);
  assign accept = bus.i_exu_valid && ready;

  assign new_mem = bus.i_exu_ldflag | bus.i_exu_stflag;
  assign new_mis = new_mem && is_misaligned(bus.i_exu_lssize, bus.i_exu_exres[2:0]);
  assign new_go  = new_mem && !new_mis;
  assign new_st  = new_go && bus.i_exu_stflag;

  lsu_ldext u_ldext (
    .rdata_i (bus.i_dmem_rdata),
    .off_i   (exres_q[2:0]),
    .size_i  (size_q),
    .uns_i   (uns_q),
    .data_o  (ld_data)
  );

  // Next state, capture of a new instruction and load-result update
  always_comb begin
    state_d    = state_q;
    exres_d    = exres_q;
    lsres_d    = lsres_q;
    addr_d     = addr_q;
    rdid_d     = rdid_q;
    rdwen_d    = rdwen_q;
    ldflag_d   = ldflag_q;
    stflag_d   = stflag_q;
    misalign_d = misalign_q;
    uns_d      = uns_q;
    size_d     = size_q;
    wen_d      = wen_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;

    unique case (state_q)
      StIdle: if (accept) state_d = new_go ? StReq : StDone;
      StReq:  if (bus.i_dmem_gnt) state_d = stflag_q ? StDone : StWait;
      StWait: begin
        if (bus.i_dmem_rvalid) begin
          state_d = StDone;
          lsres_d = ld_data;
        end
      end
      StDone: begin
        if (bus.i_wbu_ready) state_d = accept ? (new_go ? StReq : StDone) : StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      exres_d    = bus.i_exu_exres;
      lsres_d    = '0;
      rdid_d     = bus.i_exu_rdid;
      rdwen_d    = bus.i_exu_rdwen && !new_mis;
      ldflag_d   = bus.i_exu_ldflag;
      stflag_d   = bus.i_exu_stflag;
      misalign_d = new_mis;
      uns_d      = bus.i_exu_lsuns;
      size_d     = bus.i_exu_lssize;
      addr_d     = new_go ? {bus.i_exu_exres[CPU_WIDTH-1:3], 3'b000} : '0;
      wen_d      = new_st;
      wmask_d    = new_st ? (size_mask(bus.i_exu_lssize) << bus.i_exu_exres[2:0]) : '0;
      wdata_d    = new_st ? (bus.i_exu_rs2 << {bus.i_exu_exres[2:0], 3'b000}) : '0;
    end

    // Handshake outputs are registered copies of the state decode
    req_d   = (state_d == StReq);
    valid_d = (state_d == StDone);
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      exres_q    <= '0;
      lsres_q    <= '0;
      addr_q     <= '0;
      rdid_q     <= '0;
      rdwen_q    <= 1'b0;
      ldflag_q   <= 1'b0;
      stflag_q   <= 1'b0;
      misalign_q <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      exres_q    <= exres_d;
      lsres_q    <= lsres_d;
      addr_q     <= addr_d;
      rdid_q     <= rdid_d;
      rdwen_q    <= rdwen_d;
      ldflag_q   <= ldflag_d;
      stflag_q   <= stflag_d;
      misalign_q <= misalign_d;
      uns_q      <= uns_d;
      size_q     <= size_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.o_lsu_ready    = ready;
  assign bus.o_lsu_valid    = valid_q;
  assign bus.o_lsu_exres    = exres_q;
  assign bus.o_lsu_lsres    = lsres_q;
  assign bus.o_lsu_rdid     = rdid_q;
  assign bus.o_lsu_rdwen    = rdwen_q;
  assign bus.o_lsu_ldflag   = ldflag_q;
  assign bus.o_lsu_misalign = misalign_q;
  assign bus.o_dmem_req     = req_q;
  assign bus.o_dmem_wen     = wen_q;
  assign bus.o_dmem_addr    = addr_q;
  assign bus.o_dmem_wdata   = wdata_q;
  assign bus.o_dmem_wmask   = wmask_q;

endmodule
